// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register file size defaults
package regfile_pkg;
   localparam int XLEN_DEF     = 32;
   localparam int NREGS_DEF    = 32;
   localparam int NRD_DEF      = 2;
   localparam int ZERO_REG_DEF = 1;
endpackage

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - one combinational read port with bypass and busy lookup
module rf_read_port
   import regfile_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int NREGS    = NREGS_DEF,
   parameter int ZERO_REG = ZERO_REG_DEF,
   localparam int AW      = $clog2(NREGS)
) (
   input  logic [AW-1:0]   raddr,
   input  logic [XLEN-1:0] regs [NREGS],
   input  logic [NREGS-1:0] busy,
   input  logic            byp_en,
   input  logic [AW-1:0]   waddr,
   input  logic [XLEN-1:0] wdata,
   output logic [XLEN-1:0] rdata,
   output logic            rbusy
);

   logic is_zero;

   // Register 0 is treated as a constant only when the zero register is enabled.
   always_comb begin
      is_zero = (ZERO_REG != 0) && (raddr == '0);
   end

   // Same-cycle write wins over storage; busy is the registered scoreboard bit only.
   always_comb begin
      if (byp_en && (waddr == raddr)) begin
         rdata = wdata;
      end else if (is_zero) begin
         rdata = '0;
      end else begin
         rdata = regs[raddr];
      end
      rbusy = is_zero ? 1'b0 : busy[raddr];
   end

endmodule

// File: rtl/regfile_ckpt.sv
// rtl/regfile_ckpt.sv - register file with busy scoreboard and one-slot checkpoint
module regfile_ckpt
   import regfile_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int NREGS    = NREGS_DEF,
   parameter int NRD      = NRD_DEF,
   parameter int ZERO_REG = ZERO_REG_DEF,
   localparam int AW      = $clog2(NREGS)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [NRD*AW-1:0]   raddr_i,
   output logic [NRD*XLEN-1:0] rdata_o,
   output logic [NRD-1:0]      rbusy_o,
   input  logic                we_i,
   input  logic [AW-1:0]       waddr_i,
   input  logic [XLEN-1:0]     wdata_i,
   input  logic                bset_i,
   input  logic [AW-1:0]       bset_addr_i,
   input  logic                ckpt_save_i,
   input  logic                ckpt_restore_i,
   output logic                ckpt_valid_o
);

   logic [XLEN-1:0]  regs   [NREGS];
   logic [XLEN-1:0]  shadow [NREGS];
   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] busy_next;
   logic             wr_eff;
   logic             bset_eff;
   logic             restore_eff;
   logic             save_eff;
   logic             byp_en;

   // A restore flushes the cycle: it drops the write and the issue, and wins over save.
   always_comb begin
      wr_eff      = we_i && !ckpt_restore_i && !((ZERO_REG != 0) && (waddr_i == '0));
      bset_eff    = bset_i && !ckpt_restore_i && !((ZERO_REG != 0) && (bset_addr_i == '0));
      restore_eff = ckpt_restore_i && ckpt_valid_o;
      save_eff    = ckpt_save_i && !ckpt_restore_i;
      byp_en      = wr_eff && rst_ni;
   end

   // Architectural state: restore copies the whole shadow, otherwise a single write.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (restore_eff) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= shadow[i];
      end else if (wr_eff) begin
         regs[waddr_i] <= wdata_i;
      end
   end

   // Shadow captures the post-write state so a save alongside a write keeps that write.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NREGS; i++) shadow[i] <= '0;
      end else if (save_eff) begin
         for (int i = 0; i < NREGS; i++) begin
            shadow[i] <= (wr_eff && (waddr_i == AW'(i))) ? wdata_i : regs[i];
         end
      end
   end

   // Checkpoint slot is one-shot: any restore request empties it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ckpt_valid_o <= 1'b0;
      end else if (ckpt_restore_i) begin
         ckpt_valid_o <= 1'b0;
      end else if (save_eff) begin
         ckpt_valid_o <= 1'b1;
      end
   end

   // Clear applied before set so a new producer issued this cycle keeps the bit.
   always_comb begin
      busy_next = busy;
      if (wr_eff)   busy_next[waddr_i]     = 1'b0;
      if (bset_eff) busy_next[bset_addr_i] = 1'b1;
   end

   // Scoreboard: a restore wipes every pending producer.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy <= '0;
      end else if (ckpt_restore_i) begin
         busy <= '0;
      end else begin
         busy <= busy_next;
      end
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      rf_read_port #(
         .XLEN     (XLEN),
         .NREGS    (NREGS),
         .ZERO_REG (ZERO_REG)
      ) u_port (
         .raddr  (raddr_i[k*AW +: AW]),
         .regs   (regs),
         .busy   (busy),
         .byp_en (byp_en),
         .waddr  (waddr_i),
         .wdata  (wdata_i),
         .rdata  (rdata_o[k*XLEN +: XLEN]),
         .rbusy  (rbusy_o[k])
      );
   end

endmodule

// File: tb/tb_regfile_ckpt.sv
// tb/tb_regfile_ckpt.sv - randomized self-checking bench for regfile_ckpt
module tb_regfile_ckpt;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [9:0]  raddr = '0;
   logic [63:0] rdata;
   logic [1:0]  rbusy;
   logic        we = 1'b0;
   logic [4:0]  waddr = '0;
   logic [31:0] wdata = '0;
   logic        bset = 1'b0;
   logic [4:0]  bset_addr = '0;
   logic        save = 1'b0;
   logic        restore = 1'b0;
   logic        valid;

   logic [11:0]  w_raddr = '0;
   logic [191:0] w_rdata;
   logic [2:0]   w_rbusy;
   logic         w_we = 1'b0;
   logic [3:0]   w_waddr = '0;
   logic [63:0]  w_wdata = '0;
   logic         w_bset = 1'b0;
   logic [3:0]   w_bset_addr = '0;
   logic         w_save = 1'b0;
   logic         w_restore = 1'b0;
   logic         w_valid;

   int total = 0;
   int bad = 0;

   logic [31:0] m_regs   [32];
   logic [31:0] m_shadow [32];
   bit          m_busy   [32];
   bit          m_valid;

   always #5 clk = ~clk;

   regfile_ckpt u_dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .raddr_i        (raddr),
      .rdata_o        (rdata),
      .rbusy_o        (rbusy),
      .we_i           (we),
      .waddr_i        (waddr),
      .wdata_i        (wdata),
      .bset_i         (bset),
      .bset_addr_i    (bset_addr),
      .ckpt_save_i    (save),
      .ckpt_restore_i (restore),
      .ckpt_valid_o   (valid)
   );

   regfile_ckpt #(
      .XLEN     (64),
      .NREGS    (16),
      .NRD      (3),
      .ZERO_REG (0)
   ) u_wide (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .raddr_i        (w_raddr),
      .rdata_o        (w_rdata),
      .rbusy_o        (w_rbusy),
      .we_i           (w_we),
      .waddr_i        (w_waddr),
      .wdata_i        (w_wdata),
      .bset_i         (w_bset),
      .bset_addr_i    (w_bset_addr),
      .ckpt_save_i    (w_save),
      .ckpt_restore_i (w_restore),
      .ckpt_valid_o   (w_valid)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = '0;
         m_shadow[i] = '0;
         m_busy[i] = 1'b0;
      end
      m_valid = 1'b0;
   endtask

   function automatic logic [31:0] exp_data(input logic [4:0] a);
      if (we && !restore && waddr != 0 && waddr == a) return wdata;
      if (a == 0) return '0;
      return m_regs[a];
   endfunction

   function automatic logic exp_busy(input logic [4:0] a);
      if (a == 0) return 1'b0;
      return m_busy[a];
   endfunction

   task automatic model_edge();
      if (restore) begin
         if (m_valid) for (int i = 0; i < 32; i++) m_regs[i] = m_shadow[i];
         for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
         m_valid = 1'b0;
      end else begin
         if (we && waddr != 0) begin
            m_regs[waddr] = wdata;
            m_busy[waddr] = 1'b0;
         end
         if (bset && bset_addr != 0) m_busy[bset_addr] = 1'b1;
         if (save) begin
            for (int i = 0; i < 32; i++) m_shadow[i] = m_regs[i];
            m_valid = 1'b1;
         end
      end
   endtask

   task automatic set_in(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic b, input logic [4:0] ba, input logic sv, input logic rs,
                         input logic [4:0] r0, input logic [4:0] r1);
      we = w; waddr = wa; wdata = wd; bset = b; bset_addr = ba;
      save = sv; restore = rs; raddr = {r1, r0};
   endtask

   task automatic look();
      #2;
      chk("rdata0", {32'h0, rdata[31:0]}, {32'h0, exp_data(raddr[4:0])});
      chk("rdata1", {32'h0, rdata[63:32]}, {32'h0, exp_data(raddr[9:5])});
      chk("rbusy0", {63'h0, rbusy[0]}, {63'h0, exp_busy(raddr[4:0])});
      chk("rbusy1", {63'h0, rbusy[1]}, {63'h0, exp_busy(raddr[9:5])});
      chk("valid", {63'h0, valid}, {63'h0, m_valid});
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      for (int a = 0; a < 32; a++) begin
         raddr = {a[4:0], a[4:0]};
         we = 1'b1; waddr = a[4:0]; wdata = $urandom;
         #1;
         chk("rst_rdata", rdata, 64'h0);
         chk("rst_rbusy", {62'h0, rbusy}, 64'h0);
         chk("rst_valid", {63'h0, valid}, 64'h0);
      end
      we = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      set_in(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 5, 5); look();
      chk("bypass_x5", {32'h0, rdata[31:0]}, 64'hDEADBEEF); tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 5, 1); look();
      chk("held_x5", {32'h0, rdata[31:0]}, 64'hDEADBEEF); tick();
      set_in(1, 0, 32'h1234, 0, 0, 0, 0, 0, 0); look();
      chk("x0_bypass", {32'h0, rdata[31:0]}, 64'h0); tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); look();
      chk("x0_after", {32'h0, rdata[31:0]}, 64'h0); tick();

      set_in(0, 0, 0, 1, 7, 0, 0, 7, 0); look();
      chk("busy_pre", {63'h0, rbusy[0]}, 64'h0); tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 7, 0); look();
      chk("busy_set", {63'h0, rbusy[0]}, 64'h1); tick();
      set_in(1, 7, 32'h10, 0, 0, 0, 0, 7, 0); look();
      chk("busy_wr_cycle", {63'h0, rbusy[0]}, 64'h1); tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 7, 0); look();
      chk("busy_clr", {63'h0, rbusy[0]}, 64'h0);
      chk("x7_val", {32'h0, rdata[31:0]}, 64'h10); tick();
      set_in(1, 7, 32'h20, 1, 7, 0, 0, 7, 0); look(); tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 7, 0); look();
      chk("busy_set_wins", {63'h0, rbusy[0]}, 64'h1); tick();

      set_in(1, 3, 32'h11, 0, 0, 0, 0, 3, 0); look(); tick();
      set_in(1, 3, 32'h22, 0, 0, 1, 0, 3, 0); look(); tick();
      set_in(1, 3, 32'h33, 1, 9, 0, 0, 3, 9); look();
      chk("ckpt_valid1", {63'h0, valid}, 64'h1); tick();
      set_in(1, 4, 32'h77, 0, 0, 0, 1, 3, 9); look();
      chk("restore_old", {32'h0, rdata[31:0]}, 64'h33); tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 3, 9); look();
      chk("restore_new", {32'h0, rdata[31:0]}, 64'h22);
      chk("restore_busy", {63'h0, rbusy[1]}, 64'h0);
      chk("ckpt_valid0", {63'h0, valid}, 64'h0); tick();

      set_in(1, 4, 32'h44, 0, 0, 1, 0, 4, 0); look(); tick();
      set_in(1, 4, 32'h55, 0, 0, 0, 1, 4, 0); look();
      chk("no_bypass_rst", {32'h0, rdata[31:0]}, 64'h44); tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 4, 0); look();
      chk("wr_dropped", {32'h0, rdata[31:0]}, 64'h44); tick();

      set_in(1, 12, 32'h66, 0, 0, 0, 0, 12, 0); look(); tick();
      set_in(0, 0, 0, 1, 12, 0, 0, 12, 0); look(); tick();
      set_in(0, 0, 0, 0, 0, 0, 1, 12, 0); look(); tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 12, 0); look();
      chk("flush_keep", {32'h0, rdata[31:0]}, 64'h66);
      chk("flush_busy", {63'h0, rbusy[0]}, 64'h0); tick();

      set_in(0, 0, 0, 0, 0, 1, 0, 0, 0); look(); tick();
      set_in(0, 0, 0, 0, 0, 1, 1, 0, 0); look(); tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); look();
      chk("save_rst_same", {63'h0, valid}, 64'h0); tick();

      for (int n = 0; n < 500; n++) begin
         set_in(1'($urandom_range(0, 1)), 5'($urandom), $urandom,
                1'($urandom_range(0, 2) == 0), 5'($urandom),
                1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 11) == 0),
                5'($urandom), 5'($urandom));
         if (n % 7 == 0) raddr[9:5] = raddr[4:0];
         look();
         tick();
      end

      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      w_we = 1'b1; w_waddr = 4'd0; w_wdata = 64'hFFFF_FFFF_0000_0001; w_raddr = '0;
      #2;
      for (int k = 0; k < 3; k++) chk("wide_bypass", w_rdata[k*64 +: 64], 64'hFFFF_FFFF_0000_0001);
      tick();
      w_we = 1'b0; w_bset = 1'b1; w_bset_addr = 4'd0;
      #2;
      for (int k = 0; k < 3; k++) chk("wide_x0", w_rdata[k*64 +: 64], 64'hFFFF_FFFF_0000_0001);
      tick();
      w_bset = 1'b0;
      #2;
      chk("wide_busy_x0", {61'h0, w_rbusy}, 64'h7);
      tick();

      set_in(1, 9, 32'hABCD, 1, 10, 1, 0, 9, 10);
      #3;
      rst_n = 1'b0;
      model_reset();
      set_in(0, 9, 0, 0, 0, 0, 0, 9, 10);
      #1;
      chk("async_rdata", rdata, 64'h0);
      chk("async_rbusy", {62'h0, rbusy}, 64'h0);
      chk("async_valid", {63'h0, valid}, 64'h0);
      chk("async_wide", {61'h0, w_rbusy}, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      look();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_ckpt.md
Name: regfile_ckpt

Overview:
Parametrised integer register file for the pipelined RISC-V core: NRD combinational read ports, one write port with write-through bypass, optional hardwired-zero register. Adds a per-register busy scoreboard for the issue stage and a single-slot architectural checkpoint, so the branch-predictor recovery path can revert the whole register state in one cycle on a mispredict.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of 2, >=2)
NRD, 2, number of read ports (>=1)
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes/busy-set; 0 = register 0 is ordinary
AW, $clog2(NREGS), derived address width (localparam, not overridable)

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_ni  in  1  asynchronous active-low reset
raddr_i  in  NRD*AW  read addresses, port k at bits [k*AW +: AW]
rdata_o  out  NRD*XLEN  read data, port k at [k*XLEN +: XLEN]
rbusy_o  out  NRD  port k source register has a pending producer
we_i  in  1  write enable
waddr_i  in  AW  write address
wdata_i  in  XLEN  write data
bset_i  in  1  mark register bset_addr_i busy (instruction issued)
bset_addr_i  in  AW  destination of issued instruction
ckpt_save_i  in  1  capture checkpoint
ckpt_restore_i  in  1  revert to checkpoint
ckpt_valid_o  out  1  checkpoint slot holds a saved state

Behaviour:
- Reset (rst_ni low, async): all registers, shadow copy and busy bits = 0; ckpt_valid_o = 0. Reads during reset return 0, rbusy_o = 0.
- Write effective: wr_eff = we_i & !ckpt_restore_i & !(ZERO_REG & waddr_i==0). On edge: reg[waddr_i] <= wdata_i.
- Read (combinational, 0 latency), per port: if wr_eff & waddr_i==raddr -> wdata_i (bypass); else if ZERO_REG & raddr==0 -> 0; else reg[raddr].
- rbusy_o[k] = busy[raddr_k], registered value only (no bypass of same-cycle set/clear); with ZERO_REG, register 0 always 0.
- Busy update per edge, priority high->low: ckpt_restore_i clears all busy bits; else bset_i (not to reg 0 when ZERO_REG) sets busy[bset_addr_i]; wr_eff clears busy[waddr_i]. Same register set and cleared in one cycle -> stays set (new producer wins).
- Checkpoint save (ckpt_save_i & !ckpt_restore_i): shadow <= post-write state, i.e. includes this cycle's wr_eff; ckpt_valid_o <= 1. Repeated save overwrites.
- Restore (ckpt_restore_i & ckpt_valid_o): reg <= shadow for all entries; same-cycle write and bset dropped; ckpt_valid_o <= 0 (one-shot). Bypass disabled in restore cycle; reads return pre-restore array, restored values visible next cycle.
- Restore with ckpt_valid_o=0: registers unchanged, write still dropped, busy still cleared (flush semantics), valid stays 0.
- Save + restore same cycle: restore wins, save ignored, ckpt_valid_o=0 afterwards.
- Reset asserted mid-operation: state cleared immediately, pending save/restore lost.
- NRD ports may share an address; all return identical data.

Decomposition:
- Package regfile_pkg: default XLEN/NREGS/NRD constants, shared with decode and hazard unit.
- Sub-module rf_read_port: one port's address decode, zero-register mux, bypass mux and busy lookup; instantiated NRD times via generate.
- Storage, shadow, busy vector and checkpoint control stay in top.

Test Plan:
- Reset then read all 32 addresses on both ports -> rdata 0, rbusy 0, ckpt_valid_o 0.
- we=1 waddr=5 wdata=0xDEADBEEF, raddr0=5 same cycle -> rdata0=0xDEADBEEF combinationally; next cycle reg5 holds it. we=1 waddr=0 wdata=0x1234 (ZERO_REG=1) -> x0 reads 0.
- bset x7, later write x7=0x10 -> rbusy=1 until write edge, then 0; bset x7 and write x7 same cycle -> rbusy stays 1.
- x3=0x11, save in same cycle as write x3=0x22, then write x3=0x33, restore -> x3 reads 0x33 in restore cycle, 0x22 next cycle, ckpt_valid_o 1->0, all busy cleared.
- Restore with write x4=0x55 same cycle -> write dropped, x4 keeps old value; restore with no valid checkpoint -> registers unchanged, busy cleared.
- Parameter sweep NREGS=16 NRD=3 XLEN=64 ZERO_REG=0: write x0=0xFFFF_FFFF_0000_0001 -> all 3 ports read it back when addressed 0.
